// File: rtl/bbs_rng_buffer_pkg.sv
// Shared types and constants for the BBS word buffer and its FIFO.
package bbs_pkg;

  localparam int unsigned BBS_WORD_W       = 32;
  localparam int unsigned BBS_REPEAT_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    WAIT_CLR = 3'd2,
    WAIT_RES = 3'd3,
    RELEASE  = 3'd4
  } bbs_buf_state_t;

endpackage

// File: rtl/bbs_rng_buffer_if.sv
// Generator request/result signals plus the valid/ready read port.
// master: the buffer side; slave: generator and reader side.
interface bbs_rng_buffer_if #(
  parameter int unsigned WIDTH = bbs_pkg::BBS_WORD_W
);

  logic             gen_start;
  logic             gen_keep_m;
  logic             gen_use_xnext;
  logic [WIDTH-1:0] gen_result;
  logic             gen_result_valid;
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output gen_start, gen_keep_m, gen_use_xnext, rd_valid, rd_data,
    input  gen_result, gen_result_valid, rd_ready
  );

  modport slave (
    input  gen_start, gen_keep_m, gen_use_xnext, rd_valid, rd_data,
    output gen_result, gen_result_valid, rd_ready
  );

endinterface

// File: rtl/bbs_rng_buffer_word_fifo.sv
// Small synchronous word FIFO with registered head data, flush and level.
module bbs_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    pop,
  input  logic                    flush,
  output logic                    rd_valid,
  output logic [WIDTH-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_n;
  logic [LW-1:0]    cnt_q, cnt_pop_c, cnt_n;
  logic             pop_c, push_c, valid_q;
  logic [WIDTH-1:0] data_q, head_n;

  // Qualify requests and compute the next count and head word.
  always_comb begin
    pop_c     = pop && (cnt_q != '0);
    push_c    = push && ((cnt_q != LW'(DEPTH)) || pop_c);
    rd_ptr_n  = rd_ptr_q + AW'(pop_c);
    cnt_pop_c = cnt_q - LW'(pop_c);
    cnt_n     = cnt_pop_c + LW'(push_c);
    head_n    = (cnt_pop_c == '0) ? wdata : mem_q[rd_ptr_n];
  end

  // Storage array; no reset needed since reads are gated by the count.
  always_ff @(posedge clk) begin
    if (push_c && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers, occupancy and registered head; flush overrides push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push_c);
      rd_ptr_q <= rd_ptr_n;
      cnt_q    <= cnt_n;
      valid_q  <= (cnt_n != '0);
      if (cnt_n != '0) data_q <= head_n;
    end
  end

  assign rd_valid = valid_q;
  assign rd_data  = data_q;
  assign level    = cnt_q;

endmodule

// File: rtl/bbs_rng_buffer.sv
// Sequencer and prefetch buffer for the 32-bit BBS generator.
// Optional repeated-word detection: define BBS_RNG_REPEAT_CHECK_EN.
module bbs_rng_buffer
  import bbs_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = BBS_WORD_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        reseed,
  bbs_rng_buffer_if.master            bus,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        busy,
  output logic                        rng_fault,
  output logic [BBS_REPEAT_CNT_W-1:0] repeat_cnt
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  bbs_buf_state_t state_q, state_d;
  logic first_req_q, discard_q;
  logic start_q, keep_m_q, use_xnext_q, busy_q;
  logic start_d, keep_m_d, use_xnext_d, busy_d;
  logic capture_c, keep_word_c, repeat_hit_c, push_c, in_flight_c, have_room_c;

  assign capture_c   = (state_q == WAIT_RES) && bus.gen_result_valid;
  assign keep_word_c = capture_c && !discard_q;
  assign push_c      = keep_word_c && !repeat_hit_c;
  assign in_flight_c = (state_q == START) || (state_q == WAIT_CLR) || (state_q == WAIT_RES);
  assign have_room_c = level < LVL_W'(DEPTH);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; issue is held off during a reseed pulse so keep_m sees it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (en && have_room_c && !reseed) state_d = START;
      START:    state_d = WAIT_CLR;
      WAIT_CLR: if (!bus.gen_result_valid) state_d = WAIT_RES;
      WAIT_RES: if (bus.gen_result_valid) state_d = RELEASE;
      RELEASE:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Next values of the registered generator controls and busy flag.
  always_comb begin
    start_d     = (state_d == START) || (state_d == WAIT_CLR) || (state_d == WAIT_RES);
    busy_d      = (state_d != IDLE);
    keep_m_d    = keep_m_q;
    use_xnext_d = use_xnext_q;
    if ((state_q == IDLE) && (state_d == START)) begin
      keep_m_d    = !first_req_q;
      use_xnext_d = !first_req_q;
    end
  end

  // Output registers; reset drops gen_start without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q     <= 1'b0;
      keep_m_q    <= 1'b0;
      use_xnext_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      start_q     <= start_d;
      keep_m_q    <= keep_m_d;
      use_xnext_q <= use_xnext_d;
      busy_q      <= busy_d;
    end
  end

  // Sequence tracking; a reseed mid-request marks the pending word stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_req_q <= 1'b1;
      discard_q   <= 1'b0;
    end else if (reseed) begin
      first_req_q <= 1'b1;
      discard_q   <= in_flight_c && !capture_c;
    end else if (capture_c) begin
      if (discard_q) discard_q   <= 1'b0;
      else           first_req_q <= 1'b0;
    end
  end

  assign bus.gen_start     = start_q;
  assign bus.gen_keep_m    = keep_m_q;
  assign bus.gen_use_xnext = use_xnext_q;
  assign busy              = busy_q;

  bbs_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_c),
    .wdata    (bus.gen_result),
    .pop      (bus.rd_ready),
    .flush    (reseed),
    .rd_valid (bus.rd_valid),
    .rd_data  (bus.rd_data),
    .level    (level)
  );

`ifdef BBS_RNG_REPEAT_CHECK_EN
  logic [WIDTH-1:0]            prev_q;
  logic                        prev_valid_q;
  logic                        fault_q;
  logic [BBS_REPEAT_CNT_W-1:0] rcnt_q;

  assign repeat_hit_c = prev_valid_q && (bus.gen_result == prev_q);

  // Compare each kept word with the previous one; count and flag repeats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      rcnt_q       <= '0;
    end else if (reseed) begin
      prev_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      rcnt_q       <= '0;
    end else if (keep_word_c) begin
      prev_q       <= bus.gen_result;
      prev_valid_q <= 1'b1;
      if (repeat_hit_c) begin
        fault_q <= 1'b1;
        if (rcnt_q != '1) rcnt_q <= rcnt_q + BBS_REPEAT_CNT_W'(1);
      end
    end
  end

  assign rng_fault  = fault_q;
  assign repeat_cnt = rcnt_q;
`else
  assign repeat_hit_c = 1'b0;
  assign rng_fault    = 1'b0;
  assign repeat_cnt   = '0;
`endif

endmodule

// File: tb/tb_bbs_rng_buffer.sv
// Directed bench for bbs_rng_buffer with a behavioural generator model.
module tb_bbs_rng_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       reseed = 1'b0;
  logic [2:0] level;
  logic       busy;
  logic       rng_fault;
  logic [7:0] repeat_cnt;

  bbs_rng_buffer_if #(.WIDTH(W)) bus ();

  bbs_rng_buffer #(.DEPTH(DEPTH), .WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .reseed     (reseed),
    .bus        (bus),
    .level      (level),
    .busy       (busy),
    .rng_fault  (rng_fault),
    .repeat_cnt (repeat_cnt)
  );

  always #5 clk = ~clk;

  // Generator model state.
  logic [31:0] words [64];
  int  widx = 0;
  int  req_cnt = 0;
  int  lat_cfg = 2;
  int  stale_hold = 0;
  int  hold = 0;
  int  lat = 0;
  bit  armed = 1'b1;
  bit  running = 1'b0;
  bit  log_keep  [64];
  bit  log_xnext [64];

  // Generator: accepts a start once re-armed by start=0, result_valid is a level.
  always @(negedge clk) begin
    if (rst) begin
      armed   = 1'b1;
      running = 1'b0;
      bus.gen_result_valid = 1'b0;
      bus.gen_result       = 32'h0;
    end else begin
      if (!bus.gen_start) armed = 1'b1;
      else if (armed) begin
        armed   = 1'b0;
        running = 1'b1;
        hold    = stale_hold;
        lat     = lat_cfg;
        if (req_cnt < 64) begin
          log_keep[req_cnt]  = bus.gen_keep_m;
          log_xnext[req_cnt] = bus.gen_use_xnext;
        end
        req_cnt++;
      end
      if (running) begin
        if (hold > 0) hold--;
        else begin
          bus.gen_result_valid = 1'b0;
          if (lat > 0) lat--;
          else begin
            bus.gen_result       = (widx < 64) ? words[widx] : 32'h0;
            bus.gen_result_valid = 1'b1;
            widx++;
            running = 1'b0;
          end
        end
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_en();
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    check(nm, 32'(busy), 32'd0);
  endtask

  task automatic wait_level(input logic [2:0] tgt, input string nm);
    int n = 0;
    while (level !== tgt && n < 500) begin
      tick();
      n++;
    end
    check(nm, 32'(level), 32'(tgt));
  endtask

  typedef struct {
    logic        rd_ready;
    logic        exp_valid;
    logic        chk_data;
    logic [31:0] exp_data;
    logic [2:0]  exp_level;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int n;
    int k;
    int rq;
    logic [2:0] lmax;

    bus.rd_ready = 1'b0;
    for (int i = 0; i < 64; i++) words[i] = 32'h7000_0000 + 32'(i);
    words[0] = 32'h1234_5678;
    words[1] = 32'h9ABC_DEF0;
    words[2] = 32'h1357_9BDF;
    words[3] = 32'h2468_ACE0;
    words[4] = 32'h0F1E_2D3C;
    words[5] = 32'hA5A5_0001;
    words[6] = 32'hDEAD_BEEF;
    words[7] = 32'hCAFE_F00D;
    words[8] = 32'h0BAD_C0DE;

    //            rd_ready valid chk  data           level
    tbl[0] = '{1'b0, 1'b1, 1'b1, 32'h9ABC_DEF0, 3'd4};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h1357_9BDF, 3'd3};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h1357_9BDF, 3'd3};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h2468_ACE0, 3'd2};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h0F1E_2D3C, 3'd1};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h0,         3'd0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h0,         3'd0};

    // Reset state.
    repeat (3) tick();
    check("rst_gen_start",  32'(bus.gen_start), 32'd0);
    check("rst_keep_m",     32'(bus.gen_keep_m), 32'd0);
    check("rst_use_xnext",  32'(bus.gen_use_xnext), 32'd0);
    check("rst_rd_valid",   32'(bus.rd_valid), 32'd0);
    check("rst_rd_data",    bus.rd_data, 32'd0);
    check("rst_level",      32'(level), 32'd0);
    check("rst_busy",       32'(busy), 32'd0);
    check("rst_fault",      32'(rng_fault), 32'd0);
    check("rst_repeat_cnt", 32'(repeat_cnt), 32'd0);
    rst = 1'b0;

    // Prefetch fills the FIFO, then stops issuing.
    en = 1'b1;
    wait_level(3'd4, "fill_level");
    repeat (10) tick();
    check("fill_stays_full",   32'(level), 32'd4);
    check("fill_no_start",     32'(bus.gen_start), 32'd0);
    check("fill_not_busy",     32'(busy), 32'd0);
    check("fill_req_cnt",      32'(req_cnt), 32'd4);
    check("fill_req0_keep",    32'(log_keep[0]), 32'd0);
    check("fill_req0_xnext",   32'(log_xnext[0]), 32'd0);
    check("fill_req1_keep",    32'(log_keep[1]), 32'd1);
    check("fill_req3_xnext",   32'(log_xnext[3]), 32'd1);
    check("fill_head_valid",   32'(bus.rd_valid), 32'd1);
    check("fill_head_data",    bus.rd_data, 32'h1234_5678);

    // Single pop from a full FIFO triggers exactly one refill.
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    check("pop1_level", 32'(level), 32'd3);
    check("pop1_data",  bus.rd_data, 32'h9ABC_DEF0);
    wait_level(3'd4, "refill_level");
    repeat (10) tick();
    check("refill_req_cnt", 32'(req_cnt), 32'd5);
    check("refill_keep",    32'(log_keep[4]), 32'd1);
    en = 1'b0;

    // Table-driven drain with no new requests.
    for (int i = 0; i < 7; i++) begin
      bus.rd_ready = tbl[i].rd_ready;
      tick();
      check($sformatf("drain_%0d_valid", i), 32'(bus.rd_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].chk_data)
        check($sformatf("drain_%0d_data", i), bus.rd_data, tbl[i].exp_data);
      check($sformatf("drain_%0d_level", i), 32'(level), 32'(tbl[i].exp_level));
    end
    bus.rd_ready = 1'b0;
    check("drain_no_issue", 32'(req_cnt), 32'd5);

    // Stale result_valid held high after start: only the new word is stored.
    stale_hold = 4;
    pulse_en();
    wait_idle("stale_idle");
    repeat (5) tick();
    check("stale_level",   32'(level), 32'd1);
    check("stale_data",    bus.rd_data, 32'hA5A5_0001);
    check("stale_req_cnt", 32'(req_cnt), 32'd6);
    stale_hold = 0;

    // Reseed while waiting for the result: flush and discard that word.
    lat_cfg = 8;
    pulse_en();
    n = 0;
    while (!(bus.gen_start && !bus.gen_result_valid) && n < 50) begin
      tick();
      n++;
    end
    check("reseed_found_wait", 32'(bus.gen_start && !bus.gen_result_valid), 32'd1);
    tick();
    tick();
    reseed = 1'b1;
    tick();
    reseed = 1'b0;
    check("reseed_level",    32'(level), 32'd0);
    check("reseed_rd_valid", 32'(bus.rd_valid), 32'd0);
    wait_idle("reseed_idle");
    check("reseed_discard",  32'(level), 32'd0);
    check("reseed_req6_keep", 32'(log_keep[6]), 32'd1);
    lat_cfg = 2;
    pulse_en();
    wait_idle("reseed_next_idle");
    check("reseed_next_level", 32'(level), 32'd1);
    check("reseed_next_data",  bus.rd_data, 32'hCAFE_F00D);
    check("reseed_next_keep",  32'(log_keep[7]), 32'd0);
    check("reseed_next_xnext", 32'(log_xnext[7]), 32'd0);

    // Push and pop in the same cycle keep the level constant.
    pulse_en();
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(bus.gen_start && bus.gen_result_valid) && n < 50);
    bus.rd_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rd_ready = 1'b0;
    check("pushpop_level", 32'(level), 32'd1);
    check("pushpop_valid", 32'(bus.rd_valid), 32'd1);
    check("pushpop_data",  bus.rd_data, 32'h0BAD_C0DE);
    wait_idle("pushpop_idle");

    // Continuous reading while prefetching: order follows capture order.
    bus.rd_ready = 1'b1;
    en = 1'b1;
    k = 0;
    n = 0;
    lmax = 3'd0;
    while (k < 6 && n < 600) begin
      if (level > lmax) lmax = level;
      if (bus.rd_valid) begin
        check($sformatf("stream_%0d", k), bus.rd_data, words[8 + k]);
        k++;
      end
      tick();
      n++;
    end
    check("stream_count", 32'(k), 32'd6);
    check("stream_level_max", 32'(lmax), 32'd1);
    en = 1'b0;
    wait_idle("stream_idle");
    n = 0;
    while (level != 3'd0 && n < 50) begin
      tick();
      n++;
    end
    bus.rd_ready = 1'b0;
    check("stream_drained", 32'(level), 32'd0);

    // Two identical words from the generator.
    reseed = 1'b1;
    tick();
    reseed = 1'b0;
    if (widx < 63) begin
      words[widx]     = 32'h5555_5555;
      words[widx + 1] = 32'h5555_5555;
    end
    rq = req_cnt;
    pulse_en();
    wait_idle("rep_idle0");
    pulse_en();
    wait_idle("rep_idle1");
    check("rep_req_keep0", 32'(log_keep[rq]), 32'd0);
    check("rep_req_keep1", 32'(log_keep[rq + 1]), 32'd1);
    check("rep_head",      bus.rd_data, 32'h5555_5555);
`ifdef BBS_RNG_REPEAT_CHECK_EN
    check("rep_level", 32'(level), 32'd1);
    check("rep_cnt",   32'(repeat_cnt), 32'd1);
    check("rep_fault", 32'(rng_fault), 32'd1);
    reseed = 1'b1;
    tick();
    reseed = 1'b0;
    check("rep_clr_cnt",   32'(repeat_cnt), 32'd0);
    check("rep_clr_fault", 32'(rng_fault), 32'd0);
    check("rep_clr_level", 32'(level), 32'd0);
`else
    check("rep_level", 32'(level), 32'd2);
    check("rep_cnt",   32'(repeat_cnt), 32'd0);
    check("rep_fault", 32'(rng_fault), 32'd0);
`endif

    // Asynchronous reset in the middle of a request.
    pulse_en();
    tick();
    check("arst_start_before", 32'(bus.gen_start), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_start", 32'(bus.gen_start), 32'd0);
    check("arst_busy",  32'(busy), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_valid", 32'(bus.rd_valid), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
